timer_sequencer: RTL and testbench
==================================

TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per count tick (1 Hz at 50 MHz); legal range >= 2.
REQ-002 Parameter HOLD_CYCLES, default 25000000, clk cycles a held increment button must stay high before auto-repeat starts (AUTO_REPEAT_EN only).
REQ-003 Parameter REPEAT_CYCLES, default 5000000, clk cycles between auto-repeat pulses (AUTO_REPEAT_EN only).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 btn_start  in  1  debounced, clk-synchronous start/pause/acknowledge button level.
REQ-007 btn_mode  in  1  debounced count-direction toggle button level.
REQ-008 btn_inc_sec / btn_inc_min  in  1 each  debounced set-time button levels.
REQ-009 finish  in  1  terminal-count flag from the minutes/seconds counter.
REQ-010 enable  out  1  one-cycle count strobe to the counter.
REQ-011 forward  out  1  count direction to the counter: 1 = up, 0 = down.
REQ-012 incrementSeconds / incrementMinutes  out  1 each  one-cycle set strobes to the counter.
REQ-013 counter_reset  out  1  one-cycle clear pulse to the counter.
REQ-014 state  out  3  current FSM state code.
REQ-015 alarm  out  1  high while the timer is finished and unacknowledged.

Function
REQ-016 Edge detect: a press is detected in the cycle where the button is 1 and its registered previous value is 0; every strobe output is registered and asserts in the cycle after detection, for exactly one cycle.
REQ-017 FSM states: IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4; codes 5-7 unreachable and recover to IDLE on the next cycle.
REQ-018 IDLE: start press -> RUN; inc_sec or inc_min press -> SET plus the matching strobe.
REQ-019 SET: inc presses produce strobes; start press -> RUN.
REQ-020 RUN: start press -> PAUSE; finish=1 -> DONE.
REQ-021 PAUSE: start press -> RUN; finish is ignored.
REQ-022 DONE: alarm=1; start press -> IDLE with counter_reset pulsed one cycle.
REQ-023 Mode press toggles forward only in IDLE or SET; it is ignored in RUN, PAUSE and DONE.
REQ-024 Increment presses are ignored in RUN, PAUSE and DONE.
REQ-025 Prescaler: 0..TICK_DIV-1 wrapping counter advancing only in RUN; it clears to 0 on every entry to RUN and holds its value in all other states.
REQ-026 enable pulses for one cycle in the cycle after the prescaler reaches TICK_DIV-1, and only while in RUN.
REQ-027 Simultaneous start and inc presses: start wins; the inc press is dropped.
REQ-028 Simultaneous inc_sec and inc_min presses: both strobes assert in the same cycle.
REQ-029 Simultaneous finish and start in RUN: finish wins -> DONE; the start press is consumed.
REQ-030 No enable pulse is issued in the cycle the FSM leaves RUN.

Reset
REQ-031 While reset=1: state=IDLE, enable=0, incrementSeconds=0, incrementMinutes=0, alarm=0, forward=0, prescaler=0.
REQ-032 counter_reset=1 during every reset cycle.
REQ-033 Button previous-value registers load 1 during reset, so a button held through reset release produces no press.
REQ-034 Reset asserted mid-RUN or mid-DONE overrides all transitions in that cycle.

Configuration
REQ-035 Macro AUTO_REPEAT_EN defined: in IDLE/SET, an inc button held continuously for HOLD_CYCLES after its press issues a further strobe, then one strobe every REPEAT_CYCLES until release; repeat counting also respects the start-wins rule.
REQ-036 Macro AUTO_REPEAT_EN undefined: exactly one strobe per press, and no repeat counters are synthesized.

Verification (TICK_DIV=4, HOLD_CYCLES=8, REPEAT_CYCLES=3)
REQ-037 Reset for 2 cycles, then idle -> state=0, all strobes 0, forward=0, counter_reset high only during reset.
REQ-038 Start press at cycle 10 -> state=2 from cycle 11; enable pulses every 4 cycles; start press again -> state=3 and no further enable pulses.
REQ-039 In RUN, finish=1 together with a start press -> state=4 and alarm=1; a later start press -> counter_reset for one cycle, state=0, alarm=0.
REQ-040 In IDLE, inc_sec and start pressed in the same cycle -> state=2 and no incrementSeconds pulse; mode press in RUN -> forward unchanged.
REQ-041 AUTO_REPEAT_EN defined, inc_min held 20 cycles in SET -> incrementMinutes pulses at press+1, +9, +12, +15, +18; undefined -> a single pulse only.

Source files
------------

// File: rtl/timer_sequencer.sv
// timer_sequencer: control FSM for a minutes/seconds countdown/countup timer.
//
// Turns debounced button levels into one-cycle strobes for an external
// minutes/seconds counter and tracks the timer mode (idle, set, run, pause,
// done).
//
// Parameters
//   TICK_DIV      clk cycles per count tick (>= 2)
//   HOLD_CYCLES   held-button delay before auto-repeat starts
//   REPEAT_CYCLES clk cycles between auto-repeat strobes
//
// Ports
//   clk              in   single clock, rising edge
//   reset            in   synchronous, active-high reset
//   btn_start        in   start/pause/acknowledge button level
//   btn_mode         in   count-direction toggle button level
//   btn_inc_sec      in   set-seconds button level
//   btn_inc_min      in   set-minutes button level
//   finish           in   terminal-count flag from the counter
//   enable           out  one-cycle count strobe
//   forward          out  count direction, 1 = up
//   incrementSeconds out  one-cycle seconds set strobe
//   incrementMinutes out  one-cycle minutes set strobe
//   counter_reset    out  counter clear (high during reset and on acknowledge)
//   state            out  FSM state code
//   alarm            out  high while finished and unacknowledged
//
// Build option: define AUTO_REPEAT_EN to auto-repeat held increment buttons.
module timer_sequencer #(
    parameter int unsigned TICK_DIV      = 50000000,
    parameter int unsigned HOLD_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_mode,
    input  logic       btn_inc_sec,
    input  logic       btn_inc_min,
    input  logic       finish,
    output logic       enable,
    output logic       forward,
    output logic       incrementSeconds,
    output logic       incrementMinutes,
    output logic       counter_reset,
    output logic [2:0] state,
    output logic       alarm
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSet   = 3'd1;
    localparam logic [2:0] StRun   = 3'd2;
    localparam logic [2:0] StPause = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam int unsigned PreW = $clog2(TICK_DIV);
    localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : gBadTickDiv
        $error("TICK_DIV must be at least 2");
    end
    if ((HOLD_CYCLES < 1) || (REPEAT_CYCLES < 1)) begin : gBadRepeatCfg
        $error("HOLD_CYCLES and REPEAT_CYCLES must be at least 1");
    end

    logic [2:0]      stateQ, stateD;
    logic            forwardQ, forwardD;
    logic            enableQ, enableD;
    logic            incSecQ, incSecD;
    logic            incMinQ, incMinD;
    logic            counterResetQ, counterResetD;
    logic [PreW-1:0] preQ, preD;

    // Previous button levels; loaded with 1 in reset so a held button is not a press.
    logic       startPrevQ, modePrevQ;
    logic [1:0] incPrevQ;

    logic       startPress, modePress;
    logic [1:0] incBtn, incPress, incRepeat, incFire;
    logic       setPhase, canInc;

    assign incBtn     = {btn_inc_min, btn_inc_sec};
    assign startPress = btn_start & ~startPrevQ;
    assign modePress  = btn_mode & ~modePrevQ;
    assign incPress   = incBtn & ~incPrevQ;
    assign setPhase   = (stateQ == StIdle) || (stateQ == StSet);
    // A start press takes priority over any increment in the same cycle.
    assign canInc     = setPhase && !startPress;
    assign incFire    = incPress | incRepeat;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned CntMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    logic [CntW-1:0] repCntQ [2];
    logic [CntW-1:0] repCntD [2];
    logic [1:0]      armQ, armD;

    // Counter counts down to zero; the press loads the hold delay, each fire
    // reloads the repeat interval.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            armD[i]      = armQ[i];
            repCntD[i]   = repCntQ[i];
            incRepeat[i] = 1'b0;
            if (incPress[i] && canInc) begin
                armD[i]    = 1'b1;
                repCntD[i] = CntW'(HOLD_CYCLES - 1);
            end else if (!incBtn[i] || !setPhase) begin
                armD[i] = 1'b0;
            end else if (armQ[i]) begin
                if (repCntQ[i] == '0) begin
                    incRepeat[i] = canInc;
                    repCntD[i]   = CntW'(REPEAT_CYCLES - 1);
                end else begin
                    repCntD[i] = repCntQ[i] - CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            armQ <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                repCntQ[i] <= '0;
            end
        end else begin
            armQ <= armD;
            for (int i = 0; i < 2; i++) begin
                repCntQ[i] <= repCntD[i];
            end
        end
    end
`else
    assign incRepeat = 2'b00;
`endif

    always_comb begin
        stateD        = stateQ;
        forwardD      = forwardQ;
        incSecD       = 1'b0;
        incMinD       = 1'b0;
        counterResetD = 1'b0;
        case (stateQ)
            StIdle, StSet: begin
                if (modePress) begin
                    forwardD = ~forwardQ;
                end
                if (startPress) begin
                    stateD = StRun;
                end else if (|incFire) begin
                    stateD  = StSet;
                    incSecD = incFire[0];
                    incMinD = incFire[1];
                end
            end
            StRun: begin
                // finish beats a simultaneous start press, which is consumed.
                if (finish) begin
                    stateD = StDone;
                end else if (startPress) begin
                    stateD = StPause;
                end
            end
            StPause: begin
                if (startPress) begin
                    stateD = StRun;
                end
            end
            StDone: begin
                if (startPress) begin
                    stateD        = StIdle;
                    counterResetD = 1'b1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    // Tick only when staying in RUN so no strobe escapes on the exit cycle.
    always_comb begin
        enableD = (stateQ == StRun) && (stateD == StRun) && (preQ == PreMax);
        preD    = preQ;
        if ((stateD == StRun) && (stateQ != StRun)) begin
            preD = '0;
        end else if (stateQ == StRun) begin
            preD = (preQ == PreMax) ? '0 : preQ + PreW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ        <= StIdle;
            forwardQ      <= 1'b0;
            enableQ       <= 1'b0;
            incSecQ       <= 1'b0;
            incMinQ       <= 1'b0;
            counterResetQ <= 1'b0;
            preQ          <= '0;
            startPrevQ    <= 1'b1;
            modePrevQ     <= 1'b1;
            incPrevQ      <= 2'b11;
        end else begin
            stateQ        <= stateD;
            forwardQ      <= forwardD;
            enableQ       <= enableD;
            incSecQ       <= incSecD;
            incMinQ       <= incMinD;
            counterResetQ <= counterResetD;
            preQ          <= preD;
            startPrevQ    <= btn_start;
            modePrevQ     <= btn_mode;
            incPrevQ      <= incBtn;
        end
    end

    assign enable           = enableQ;
    assign forward          = forwardQ;
    assign incrementSeconds = incSecQ;
    assign incrementMinutes = incMinQ;
    // Reset drives the clear directly so the counter is held for every reset cycle.
    assign counter_reset    = counterResetQ | reset;
    assign state            = stateQ;
    assign alarm            = (stateQ == StDone);

endmodule

// File: tb/tb_timer_sequencer.sv
// Scoreboard bench for timer_sequencer (TICK_DIV=4, HOLD_CYCLES=8, REPEAT_CYCLES=3).
// Stimulus pushes expected strobe events and state snapshots; a monitor on the
// falling edge pops and compares them. Cycle N is the interval after the Nth
// rising clock edge.
module tb_timer_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc_sec = 1'b0;
    logic       btn_inc_min = 1'b0;
    logic       finish = 1'b0;
    logic       enable, forward, incrementSeconds, incrementMinutes, counter_reset, alarm;
    logic [2:0] state;

    timer_sequencer #(
        .TICK_DIV     (4),
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .btn_start       (btn_start),
        .btn_mode        (btn_mode),
        .btn_inc_sec     (btn_inc_sec),
        .btn_inc_min     (btn_inc_min),
        .finish          (finish),
        .enable          (enable),
        .forward         (forward),
        .incrementSeconds(incrementSeconds),
        .incrementMinutes(incrementMinutes),
        .counter_reset   (counter_reset),
        .state           (state),
        .alarm           (alarm)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [8:0] vec; } ev_t;
    typedef struct { int cyc; logic [4:0] vec; } sn_t;

    ev_t evQ[$];
    sn_t snQ[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    bit  done = 1'b0;

    // Event vector: {enable, incSec, incMin, counter_reset, state, forward, alarm}.
    function automatic void pushEv(int c, logic en, logic s, logic m, logic cr,
                                   logic [2:0] st, logic fw, logic al);
        ev_t e;
        e.cyc = c;
        e.vec = {en, s, m, cr, st, fw, al};
        evQ.push_back(e);
    endfunction

    // Snapshot vector: {state, forward, alarm}.
    function automatic void pushSn(int c, logic [2:0] st, logic fw, logic al);
        sn_t s;
        s.cyc = c;
        s.vec = {st, fw, al};
        snQ.push_back(s);
    endfunction

    task automatic waitCyc(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Monitor
    initial begin
        logic [8:0] act;
        logic [4:0] snAct;
        logic       pulse;
        ev_t        e;
        sn_t        s;
        forever begin
            @(negedge clk);
            if (cyc >= 1 && !done) begin
                act   = {enable, incrementSeconds, incrementMinutes, counter_reset,
                         state, forward, alarm};
                pulse = enable | incrementSeconds | incrementMinutes | counter_reset;
                while (evQ.size() > 0 && evQ[0].cyc < cyc) begin
                    e = evQ.pop_front();
                    total = total + 1;
                    bad = bad + 1;
                    $display("FAIL missing_pulse cyc=%0d got=none want=%b", e.cyc, e.vec);
                end
                if (pulse) begin
                    total = total + 1;
                    if (evQ.size() > 0 && evQ[0].cyc == cyc) begin
                        e = evQ.pop_front();
                        if (act !== e.vec) begin
                            bad = bad + 1;
                            $display("FAIL pulse_outputs cyc=%0d got=%b want=%b", cyc, act, e.vec);
                        end
                    end else begin
                        bad = bad + 1;
                        $display("FAIL unexpected_pulse cyc=%0d got=%b want=no pulse", cyc, act);
                    end
                end else if (evQ.size() > 0 && evQ[0].cyc == cyc) begin
                    e = evQ.pop_front();
                    total = total + 1;
                    bad = bad + 1;
                    $display("FAIL missing_pulse cyc=%0d got=%b want=%b", cyc, act, e.vec);
                end
                if (snQ.size() > 0 && snQ[0].cyc == cyc) begin
                    s = snQ.pop_front();
                    snAct = {state, forward, alarm};
                    total = total + 1;
                    if (snAct !== s.vec) begin
                        bad = bad + 1;
                        $display("FAIL snapshot cyc=%0d got={st,fw,al}=%b want=%b",
                                 cyc, snAct, s.vec);
                    end
                end
            end
        end
    end

    initial begin
        // Reset with btn_start held through release: no press may result.
        pushEv(1, 0, 0, 0, 1, 3'd0, 0, 0);
        pushSn(2, 3'd0, 0, 0);
        pushSn(5, 3'd0, 0, 0);
        waitCyc(2);
        reset = 1'b0;
        waitCyc(4);
        btn_start = 1'b0;

        // Start -> RUN, enables every 4 cycles; mode/inc ignored in RUN.
        waitCyc(10);
        btn_start = 1'b1;
        pushSn(11, 3'd2, 0, 0);
        pushEv(15, 1, 0, 0, 0, 3'd2, 0, 0);
        pushEv(19, 1, 0, 0, 0, 3'd2, 0, 0);
        waitCyc(11);
        btn_start = 1'b0;
        waitCyc(17);
        btn_mode = 1'b1;
        waitCyc(18);
        btn_mode = 1'b0;
        btn_inc_sec = 1'b1;
        waitCyc(19);
        btn_inc_sec = 1'b0;
        pushSn(20, 3'd2, 0, 0);

        // Pause exactly when the prescaler is at TICK_DIV-1: no enable on exit.
        waitCyc(22);
        btn_start = 1'b1;
        pushSn(23, 3'd3, 0, 0);
        waitCyc(23);
        btn_start = 1'b0;
        waitCyc(27);
        finish = 1'b1;
        waitCyc(28);
        finish = 1'b0;
        pushSn(30, 3'd3, 0, 0);

        // Resume; prescaler restarts from 0.
        waitCyc(35);
        btn_start = 1'b1;
        pushSn(36, 3'd2, 0, 0);
        pushEv(40, 1, 0, 0, 0, 3'd2, 0, 0);
        waitCyc(36);
        btn_start = 1'b0;

        // finish together with start -> DONE.
        waitCyc(41);
        btn_start = 1'b1;
        finish = 1'b1;
        pushSn(42, 3'd4, 0, 1);
        pushSn(45, 3'd4, 0, 1);
        waitCyc(42);
        btn_start = 1'b0;
        finish = 1'b0;

        // Acknowledge -> IDLE with a counter_reset pulse.
        waitCyc(47);
        btn_start = 1'b1;
        pushEv(48, 0, 0, 0, 1, 3'd0, 0, 0);
        pushSn(49, 3'd0, 0, 0);
        waitCyc(48);
        btn_start = 1'b0;

        // Start and inc_sec together in IDLE: start wins, no strobe.
        waitCyc(52);
        btn_start = 1'b1;
        btn_inc_sec = 1'b1;
        pushSn(53, 3'd2, 0, 0);
        pushEv(57, 1, 0, 0, 0, 3'd2, 0, 0);
        waitCyc(53);
        btn_start = 1'b0;
        btn_inc_sec = 1'b0;
        waitCyc(58);
        btn_start = 1'b1;
        pushSn(59, 3'd3, 0, 0);
        waitCyc(59);
        btn_start = 1'b0;
        waitCyc(62);
        btn_start = 1'b1;
        waitCyc(63);
        btn_start = 1'b0;
        finish = 1'b1;
        pushSn(64, 3'd4, 0, 1);
        waitCyc(64);
        finish = 1'b0;
        waitCyc(67);
        btn_start = 1'b1;
        pushEv(68, 0, 0, 0, 1, 3'd0, 0, 0);
        waitCyc(68);
        btn_start = 1'b0;

        // Mode toggles in IDLE and SET; increments enter SET.
        waitCyc(72);
        btn_mode = 1'b1;
        pushSn(73, 3'd0, 1, 0);
        waitCyc(73);
        btn_mode = 1'b0;
        waitCyc(75);
        btn_inc_sec = 1'b1;
        pushEv(76, 0, 1, 0, 0, 3'd1, 1, 0);
        waitCyc(76);
        btn_inc_sec = 1'b0;
        waitCyc(78);
        btn_inc_sec = 1'b1;
        btn_inc_min = 1'b1;
        pushEv(79, 0, 1, 1, 0, 3'd1, 1, 0);
        waitCyc(79);
        btn_inc_sec = 1'b0;
        btn_inc_min = 1'b0;
        waitCyc(81);
        btn_mode = 1'b1;
        pushSn(82, 3'd1, 0, 0);
        waitCyc(82);
        btn_mode = 1'b0;
        waitCyc(84);
        btn_mode = 1'b1;
        pushSn(85, 3'd1, 1, 0);
        waitCyc(85);
        btn_mode = 1'b0;

        // inc_min held for 20 cycles in SET.
        waitCyc(90);
        btn_inc_min = 1'b1;
        pushEv(91, 0, 0, 1, 0, 3'd1, 1, 0);
`ifdef AUTO_REPEAT_EN
        pushEv(99, 0, 0, 1, 0, 3'd1, 1, 0);
        pushEv(102, 0, 0, 1, 0, 3'd1, 1, 0);
        pushEv(105, 0, 0, 1, 0, 3'd1, 1, 0);
        pushEv(108, 0, 0, 1, 0, 3'd1, 1, 0);
`endif
        waitCyc(110);
        btn_inc_min = 1'b0;

        // SET -> RUN counting up, then pause.
        waitCyc(115);
        btn_start = 1'b1;
        pushSn(116, 3'd2, 1, 0);
        pushEv(120, 1, 0, 0, 0, 3'd2, 1, 0);
        waitCyc(116);
        btn_start = 1'b0;
        waitCyc(121);
        btn_start = 1'b1;
        pushSn(122, 3'd3, 1, 0);
        pushSn(125, 3'd3, 1, 0);
        waitCyc(122);
        btn_start = 1'b0;

        waitCyc(130);
        done = 1'b1;
        while (evQ.size() > 0) begin
            ev_t e;
            e = evQ.pop_front();
            total = total + 1;
            bad = bad + 1;
            $display("FAIL pending_pulse cyc=%0d got=none want=%b", e.cyc, e.vec);
        end
        while (snQ.size() > 0) begin
            sn_t s;
            s = snQ.pop_front();
            total = total + 1;
            bad = bad + 1;
            $display("FAIL pending_snapshot cyc=%0d got=none want=%b", s.cyc, s.vec);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
